// File: rtl/rca_lsq_if.sv
// OU request / data-memory port bundle for rca_lsq.
// slave is the queue's view; master is the driver/monitor side (OU + memory).
interface rca_lsq_if;
    localparam int unsigned XLEN = 32;

    // OU side
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            load;
    logic            store;
    logic            new_request;
    logic            lsq_full;
    logic [XLEN-1:0] load_data;
    logic            load_complete;

    // memory side
    logic            mem_req;
    logic            mem_rnw;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_rvalid;

    modport slave (
        input  addr, data, fn3, load, store, new_request,
        output lsq_full, load_data, load_complete,
        output mem_req, mem_rnw, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata, mem_rvalid
    );

    modport master (
        output addr, data, fn3, load, store, new_request,
        input  lsq_full, load_data, load_complete,
        input  mem_req, mem_rnw, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/rca_lsq.sv
// In-order load/store queue between one RCA operation unit and the data-memory port.
// Optional RCA_LSQ_LOAD_EXTEND_EN: align and sign/zero-extend load data inside the queue.
module rca_lsq #(
    parameter int unsigned LSQ_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    rca_lsq_if.slave   bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned PTR_W = $clog2(LSQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 2;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [2:0]      fn3;
        logic            load;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    entry_t            q_mem [LSQ_DEPTH];
    entry_t            head;
    state_t            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_rnw_q, mem_rnw_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic              load_complete_q, load_complete_d;
    logic              push, pop;
    logic [XLEN-1:0]   load_word;

    // Exactly one of load/store must be set; full is the registered view, so a same-cycle pop never helps.
    assign push = bus.new_request && !full_q && (bus.load != bus.store);
    assign head = q_mem[head_q];

    function automatic logic [3:0] store_be(input logic [2:0] fn3, input logic [1:0] off);
        logic [3:0] be;
        case (fn3)
            3'b000, 3'b100: be = 4'b0001 << off;
            3'b001, 3'b101: be = 4'b0011 << {off[1], 1'b0};
            default:        be = 4'hF;
        endcase
        return be;
    endfunction

    function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] fn3, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] w;
        case (fn3)
            3'b000, 3'b100: w = {4{d[7:0]}};
            3'b001, 3'b101: w = {2{d[15:0]}};
            default:        w = d;
        endcase
        return w;
    endfunction

`ifdef RCA_LSQ_LOAD_EXTEND_EN
    logic [XLEN-1:0] rdata_sh;

    // Shift the addressed bytes down to bit 0, then extend per the load's width/signedness.
    always_comb begin
        rdata_sh = bus.mem_rdata >> {head.addr[1:0], 3'b000};
        case (head.fn3)
            3'b000:  load_word = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            3'b001:  load_word = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            3'b100:  load_word = {24'h0, rdata_sh[7:0]};
            3'b101:  load_word = {16'h0, rdata_sh[15:0]};
            default: load_word = bus.mem_rdata;
        endcase
    end
`else
    assign load_word = bus.mem_rdata;
`endif

    // Entry storage needs no reset: count/pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[tail_q] <= '{addr: bus.addr, data: bus.data, fn3: bus.fn3, load: bus.load};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            full_q          <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_rnw_q       <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_be_q        <= '0;
            load_data_q     <= '0;
            load_complete_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            full_q          <= full_d;
            mem_req_q       <= mem_req_d;
            mem_rnw_q       <= mem_rnw_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_be_q        <= mem_be_d;
            load_data_q     <= load_data_d;
            load_complete_q <= load_complete_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        mem_req_d       = mem_req_q;
        mem_rnw_d       = mem_rnw_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_be_d        = mem_be_q;
        load_data_d     = load_data_q;
        load_complete_d = 1'b0;
        pop             = 1'b0;

        case (state_q)
            // Latch the head into the memory-port registers; they stay frozen until mem_ack.
            IDLE: begin
                if (count_q != '0) begin
                    state_d     = REQ;
                    mem_req_d   = 1'b1;
                    mem_rnw_d   = head.load;
                    mem_addr_d  = {head.addr[XLEN-1:2], 2'b00};
                    mem_be_d    = head.load ? 4'hF : store_be(head.fn3, head.addr[1:0]);
                    mem_wdata_d = head.load ? '0 : store_lanes(head.fn3, head.data);
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    if (head.load) begin
                        state_d = WAIT;
                    end else begin
                        pop     = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            // Single outstanding load: the head stays put until its data returns.
            WAIT: begin
                if (bus.mem_rvalid) begin
                    pop             = 1'b1;
                    load_data_d     = load_word;
                    load_complete_d = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_W'(LSQ_DEPTH));
    end

    assign bus.lsq_full      = full_q;
    assign bus.mem_req       = mem_req_q;
    assign bus.mem_rnw       = mem_rnw_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_be        = mem_be_q;
    assign bus.load_data     = load_data_q;
    assign bus.load_complete = load_complete_q;
endmodule

// File: tb/tb_rca_lsq.sv
// Bench for rca_lsq: directed vector table, multi-cycle corner sequences, then random traffic vs a queue model.
module tb_rca_lsq;
    localparam int unsigned DEPTH = 4;
`ifdef RCA_LSQ_LOAD_EXTEND_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rca_lsq_if bus ();
    rca_lsq #(.LSQ_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  fn3;
        logic        load;
    } req_t;

    typedef struct {
        string       name;
        logic        load;
        logic [2:0]  fn3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_ext;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.new_request = 1'b0;
        bus.load = 1'b0;
        bus.store = 1'b0;
        bus.addr = '0;
        bus.data = '0;
        bus.fn3 = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic push_one(input logic ld, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        bus.new_request = 1'b1;
        bus.load = ld;
        bus.store = ~ld;
        bus.fn3 = f;
        bus.addr = a;
        bus.data = d;
        tick();
        bus.new_request = 1'b0;
        bus.load = 1'b0;
        bus.store = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!bus.mem_req && n < 30) begin
            tick();
            n++;
        end
        chk("mem_req_timeout", 32'(bus.mem_req), 32'd1);
    endtask

    // Reference formatting of a returned word, from the byte-lane rules.
    function automatic logic [31:0] exp_load(input req_t r, input logic [31:0] rd);
        logic [31:0] sh, b, h, ext;
        sh = rd >> (8 * r.addr[1:0]);
        b = sh & 32'hFF;
        h = sh & 32'hFFFF;
        case (r.fn3)
            3'd0:    ext = (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
            3'd1:    ext = (h >= 32'd32768) ? (h + 32'hFFFF_0000) : h;
            3'd4:    ext = b;
            3'd5:    ext = h;
            default: ext = rd;
        endcase
        return EXT ? ext : rd;
    endfunction

    function automatic logic [3:0] exp_be(input req_t r);
        if (r.load) return 4'hF;
        case (r.fn3)
            3'd0:    return 4'(1 << r.addr[1:0]);
            3'd1:    return (r.addr[1:0] >= 2'd2) ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input req_t r);
        case (r.fn3)
            3'd0:    return (r.data & 32'hFF) * 32'h0101_0101;
            3'd1:    return (r.data & 32'hFFFF) * 32'h0001_0001;
            default: return r.data;
        endcase
    endfunction

    vec_t      vecs [8];
    req_t      pend [$];
    logic [31:0] seen_addr [$];
    int        n;
    int        writes;
    bit        waiting;
    bit        exp_lc;
    logic [31:0] exp_ld;
    bit        accept;
    logic [2:0] fsel;

    initial begin
        vecs[0] = '{"st_b_off3", 1'b0, 3'd0, 32'h1003, 32'h0000_00AB, 32'h0, 32'h1000, 4'b1000, 32'hABAB_ABAB, 32'h0};
        vecs[1] = '{"ld_bu_off2", 1'b1, 3'd4, 32'h2002, 32'h0, 32'h80FF_1234, 32'h2000, 4'hF, 32'h0, 32'h0000_00FF};
        vecs[2] = '{"ld_b_off2", 1'b1, 3'd0, 32'h2002, 32'h0, 32'h80FF_1234, 32'h2000, 4'hF, 32'h0, 32'hFFFF_FFFF};
        vecs[3] = '{"ld_h_off2", 1'b1, 3'd1, 32'h2002, 32'h0, 32'h80FF_1234, 32'h2000, 4'hF, 32'h0, 32'hFFFF_80FF};
        vecs[4] = '{"st_h_off1", 1'b0, 3'd1, 32'h3001, 32'h1234_BEEF, 32'h0, 32'h3000, 4'b0011, 32'hBEEF_BEEF, 32'h0};
        vecs[5] = '{"st_w", 1'b0, 3'd2, 32'h0000_0043, 32'hDEAD_BEEF, 32'h0, 32'h0000_0040, 4'hF, 32'hDEAD_BEEF, 32'h0};
        vecs[6] = '{"ld_hu_off0", 1'b1, 3'd5, 32'h10, 32'h0, 32'h1234_ABCD, 32'h10, 4'hF, 32'h0, 32'h0000_ABCD};
        vecs[7] = '{"ld_w_off3", 1'b1, 3'd2, 32'h13, 32'h0, 32'h89AB_CDEF, 32'h10, 4'hF, 32'h0, 32'h89AB_CDEF};

        idle_inputs();
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_full", 32'(bus.lsq_full), 32'd0);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_lc", 32'(bus.load_complete), 32'd0);
        chk("rst_ldata", bus.load_data, 32'd0);
        rst = 1'b1;
        tick();

        // Directed single transactions.
        foreach (vecs[i]) begin
            push_one(vecs[i].load, vecs[i].fn3, vecs[i].addr, vecs[i].data);
            chk({vecs[i].name, "_req_early"}, 32'(bus.mem_req), 32'd0);
            wait_req(n);
            chk({vecs[i].name, "_latency"}, 32'(n), 32'd1);
            chk({vecs[i].name, "_addr"}, bus.mem_addr, vecs[i].exp_addr);
            chk({vecs[i].name, "_rnw"}, 32'(bus.mem_rnw), 32'(vecs[i].load));
            chk({vecs[i].name, "_be"}, 32'(bus.mem_be), 32'(vecs[i].exp_be));
            if (!vecs[i].load) chk({vecs[i].name, "_wdata"}, bus.mem_wdata, vecs[i].exp_wdata);
            bus.mem_ack = 1'b1;
            tick();
            bus.mem_ack = 1'b0;
            chk({vecs[i].name, "_req_drop"}, 32'(bus.mem_req), 32'd0);
            if (vecs[i].load) begin
                tick();
                chk({vecs[i].name, "_lc_early"}, 32'(bus.load_complete), 32'd0);
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata = vecs[i].rdata;
                tick();
                bus.mem_rvalid = 1'b0;
                chk({vecs[i].name, "_lc"}, 32'(bus.load_complete), 32'd1);
                chk({vecs[i].name, "_ldata"}, bus.load_data, EXT ? vecs[i].exp_ext : vecs[i].rdata);
                tick();
                chk({vecs[i].name, "_lc_pulse"}, 32'(bus.load_complete), 32'd0);
            end
            tick();
        end

        // Illegal push (load and store both set) must be dropped.
        bus.new_request = 1'b1; bus.load = 1'b1; bus.store = 1'b1; bus.addr = 32'h900;
        tick();
        idle_inputs();
        repeat (4) tick();
        chk("both_dropped", 32'(bus.mem_req), 32'd0);

        // Fill with acks held low: fifth push dropped, exactly four writes in order.
        for (int k = 0; k < 5; k++) begin
            push_one(1'b0, 3'd2, 32'h100 + 32'(4 * k), 32'(k));
            if (k == 2) chk("full_after3", 32'(bus.lsq_full), 32'd0);
            if (k >= 3) chk("full_after4", 32'(bus.lsq_full), 32'd1);
        end
        bus.mem_ack = 1'b1;
        writes = 0;
        seen_addr.delete();
        for (int c = 0; c < 30; c++) begin
            if (bus.mem_req) begin
                writes++;
                seen_addr.push_back(bus.mem_addr);
            end
            tick();
        end
        bus.mem_ack = 1'b0;
        chk("full_writes", 32'(writes), 32'd4);
        foreach (seen_addr[k]) chk("full_order", seen_addr[k], 32'h100 + 32'(4 * k));
        chk("full_cleared", 32'(bus.lsq_full), 32'd0);

        // Load then store; store must wait for the delayed load return.
        push_one(1'b1, 3'd2, 32'h500, 32'h0);
        push_one(1'b0, 3'd2, 32'h600, 32'h55);
        wait_req(n);
        chk("ls_load_first", bus.mem_addr, 32'h500);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("ls_store_held", 32'(bus.mem_req), 32'd0);
            tick();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'h1122_3344;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("ls_lc", 32'(bus.load_complete), 32'd1);
        chk("ls_ldata", bus.load_data, 32'h1122_3344);
        chk("ls_store_not_yet", 32'(bus.mem_req), 32'd0);
        wait_req(n);
        chk("ls_store_addr", bus.mem_addr, 32'h600);
        chk("ls_store_rnw", 32'(bus.mem_rnw), 32'd0);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        tick();

        // Reset while waiting on a load with two more entries queued.
        push_one(1'b1, 3'd2, 32'h700, 32'h0);
        push_one(1'b0, 3'd2, 32'h704, 32'h1);
        push_one(1'b0, 3'd2, 32'h708, 32'h2);
        wait_req(n);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        rst = 1'b0;
        #1;
        chk("rstw_req_async", 32'(bus.mem_req), 32'd0);
        tick();
        chk("rstw_full", 32'(bus.lsq_full), 32'd0);
        chk("rstw_req", 32'(bus.mem_req), 32'd0);
        rst = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        tick();
        bus.mem_rvalid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.mem_req || bus.load_complete) begin
                chk("rstw_flushed", {30'h0, bus.mem_req, bus.load_complete}, 32'd0);
            end
            tick();
        end
        chk("rstw_quiet", {30'h0, bus.mem_req, bus.load_complete}, 32'd0);

        // Random traffic against a queue model.
        pend.delete();
        waiting = 1'b0;
        exp_lc = 1'b0;
        exp_ld = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd_full", 32'(bus.lsq_full), 32'(pend.size() == DEPTH));
            chk("rnd_lc", 32'(bus.load_complete), 32'(exp_lc));
            if (exp_lc) chk("rnd_ldata", bus.load_data, exp_ld);
            if (bus.mem_req) begin
                if (waiting || pend.size() == 0) begin
                    chk("rnd_spurious_req", 32'(bus.mem_req), 32'd0);
                end else begin
                    chk("rnd_addr", bus.mem_addr, {pend[0].addr[31:2], 2'b00});
                    chk("rnd_rnw", 32'(bus.mem_rnw), 32'(pend[0].load));
                    chk("rnd_be", 32'(bus.mem_be), 32'(exp_be(pend[0])));
                    if (!pend[0].load) chk("rnd_wdata", bus.mem_wdata, exp_wdata(pend[0]));
                end
            end

            bus.new_request = (cyc < 2900) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.load = 1'($urandom_range(0, 1));
            bus.store = ($urandom_range(0, 7) == 0) ? bus.load : ~bus.load;
            case ($urandom_range(0, 4))
                0: fsel = 3'd0;
                1: fsel = 3'd1;
                2: fsel = 3'd2;
                3: fsel = 3'd4;
                default: fsel = 3'd5;
            endcase
            if (!bus.load && fsel[2]) fsel = 3'd2;
            bus.fn3 = fsel;
            bus.addr = $urandom;
            bus.data = $urandom;
            bus.mem_ack = (cyc >= 2900) || ($urandom_range(0, 2) == 0);
            bus.mem_rvalid = (cyc >= 2900) || ($urandom_range(0, 2) == 0);
            bus.mem_rdata = $urandom;

            accept = bus.new_request && (pend.size() < DEPTH) && (bus.load != bus.store);
            exp_lc = 1'b0;
            if (bus.mem_req && bus.mem_ack && pend.size() != 0) begin
                if (pend[0].load) waiting = 1'b1;
                else void'(pend.pop_front());
            end else if (waiting && bus.mem_rvalid) begin
                exp_lc = 1'b1;
                exp_ld = exp_load(pend[0], bus.mem_rdata);
                void'(pend.pop_front());
                waiting = 1'b0;
            end
            if (accept) pend.push_back('{bus.addr, bus.data, bus.fn3, bus.load});
            tick();
        end
        chk("rnd_drained", 32'(pend.size()), 32'd0);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
